// File: rtl/uart_rx_deser_pkg.sv
// Shared types and default sizing for the UART receive deserialiser.
package uart_rx_deser_pkg;

    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam int unsigned DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        ALIGN  = 3'd4,
        STOP   = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_deser_if.sv
// Serial line in, deserialised word and stop-check framing out.
interface uart_rx_deser_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 rx;
    logic                 rx_s;
    logic [DATA_BITS-1:0] rx_data;
    logic                 check_stop;
    logic                 start_err;
    logic                 parity_err;
    logic                 rx_busy;

    modport master (
        output rx,
        input  rx_s, rx_data, check_stop, start_err, parity_err, rx_busy
    );

    modport slave (
        input  rx,
        output rx_s, rx_data, check_stop, start_err, parity_err, rx_busy
    );
endinterface

// File: rtl/uart_rx_deser_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; idles high.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_deser.sv
// UART receive front end: mid-bit sampling of start, data and parity, then a
// stop-bit-aligned check_stop window for the downstream stop checker.
module uart_rx_deser
    import uart_rx_deser_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic           clk,
    input  logic           rst,
    uart_rx_deser_if.slave bus
);
    localparam int unsigned CNT_W   = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W   = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF_M1 = OVERSAMPLE / 2 - 1;
    localparam int unsigned HALF_M2 = OVERSAMPLE / 2 - 2;
    localparam int unsigned LAST    = OVERSAMPLE - 1;

    rx_state_t            state;
    logic [CNT_W-1:0]     cnt;
    logic [BIT_W-1:0]     bitcnt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic [DATA_BITS:0]   shift_ext;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_s;
    logic                 start_err;
    logic                 parity_err;
    logic                 par_odd;
    logic                 cnt_last;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx),
        .q   (rx_s)
    );

    // LSB-first frame: new bits enter at the MSB end and walk down.
    assign shift_ext = {rx_s, shreg};
    assign shreg_nxt = shift_ext[DATA_BITS:1];
    assign par_odd   = 1'(PARITY_ODD);
    assign cnt_last  = (cnt == CNT_W'(LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            rx_data    <= '0;
            start_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            start_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_W'(HALF_M1)) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state  <= DATA;
                            bitcnt <= '0;
                        end else begin
                            state     <= IDLE;
                            start_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt    <= '0;
                        shreg  <= shreg_nxt;
                        bitcnt <= bitcnt + BIT_W'(1);
                        if (bitcnt == BIT_W'(DATA_BITS - 1)) begin
                            rx_data <= shreg_nxt;
                            state   <= (PARITY_EN != 0) ? PARITY : ALIGN;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    // rx_data already holds the completed word here.
                    if (cnt_last) begin
                        parity_err <= (^rx_data) ^ rx_s ^ par_odd;
                        state      <= ALIGN;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ALIGN: begin
                    // Shifts from mid-bit sampling phase to the stop-bit boundary.
                    if (cnt == CNT_W'(HALF_M2)) begin
                        state <= STOP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.rx_s       = rx_s;
    assign bus.rx_data    = rx_data;
    assign bus.start_err  = start_err;
    assign bus.parity_err = parity_err;
    assign bus.check_stop = (state == STOP);
    assign bus.rx_busy    = (state != IDLE);

endmodule
